// File: rtl/fir_ctrl.sv
// Handshake controller for a 3-tap FIR datapath: accepts samples, strobes the
// delay and output registers, holds results until consumed, flags warm-up outputs.
module fir_ctrl #(
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned WARMUP    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 ld_reg,
  output logic                 ld_out,
  output logic                 dp_rst,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_warm,
  output logic [CNT_WIDTH-1:0] sample_cnt
);

  localparam int unsigned WW = $clog2(WARMUP + 2);
  localparam logic [WW-1:0] WARM_MAX = WW'(WARMUP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [WW-1:0]        widx_q, widx_d;
  logic                 warm_q, warm_d;
  logic                 dp_rst_q;
  logic                 abort_c;

  assign abort_c = rst | clear;

  // State register; rst and clear both restart the controller.
  always_ff @(posedge clk) begin
    if (abort_c) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (ld_reg) state_d = CAPT;
      CAPT: state_d = HOLD;
      HOLD: begin
        if (out_valid && out_ready) begin
          state_d = ld_reg ? CAPT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode; in HOLD a new sample is only taken when the held result leaves.
  always_comb begin
    in_ready  = 1'b0;
    ld_out    = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: in_ready  = ~abort_c;
      CAPT: ld_out    = ~abort_c;
      HOLD: begin
        in_ready  = out_ready & ~abort_c;
        out_valid = 1'b1;
      end
      default: ;
    endcase
    ld_reg   = in_valid & in_ready;
    out_warm = out_valid & warm_q;
  end

  // Sample counter and warm-up index; the index saturates separately from the
  // counter so a narrow counter cannot disturb warm-up flagging.
  always_comb begin
    cnt_d  = cnt_q;
    widx_d = widx_q;
    warm_d = warm_q;
    if (ld_reg) begin
      if (cnt_q != {CNT_WIDTH{1'b1}}) cnt_d = cnt_q + CNT_WIDTH'(1);
      if (widx_q != WARM_MAX) widx_d = widx_q + WW'(1);
      warm_d = (widx_q < WARM_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (abort_c) begin
      cnt_q  <= '0;
      widx_q <= '0;
      warm_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      widx_q <= widx_d;
      warm_q <= warm_d;
    end
  end

  always_ff @(posedge clk) begin
    dp_rst_q <= abort_c;
  end

  assign dp_rst     = dp_rst_q;
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_fir_ctrl.sv
// Randomized self-checking bench for fir_ctrl with a bench-side FIR datapath
// (Q8 taps 64/128/64) and a transaction-level reference model.
module tb_fir_ctrl;

  logic        clk;
  logic        rst, clear, in_valid, out_ready;
  logic [15:0] x;
  logic        in_ready, ld_reg, ld_out, dp_rst, out_valid, out_warm;
  logic [15:0] sample_cnt;
  logic        in_ready3, ld_reg3, ld_out3, dp_rst3, out_valid3, out_warm3;
  logic [2:0]  sample_cnt3;
  logic [15:0] d0, d1, d2, dp_y;

  int n_checks = 0;
  int n_fail   = 0;

  fir_ctrl #(.CNT_WIDTH(16), .WARMUP(2)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready), .ld_reg(ld_reg), .ld_out(ld_out), .dp_rst(dp_rst),
    .out_valid(out_valid), .out_ready(out_ready), .out_warm(out_warm),
    .sample_cnt(sample_cnt)
  );

  fir_ctrl #(.CNT_WIDTH(3), .WARMUP(2)) dut3 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready3), .ld_reg(ld_reg3), .ld_out(ld_out3), .dp_rst(dp_rst3),
    .out_valid(out_valid3), .out_ready(out_ready), .out_warm(out_warm3),
    .sample_cnt(sample_cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath driven by the controller strobes.
  always_ff @(posedge clk) begin
    if (dp_rst) begin
      d0   <= ld_reg ? x : 16'd0;
      d1   <= 16'd0;
      d2   <= 16'd0;
      dp_y <= 16'd0;
    end else begin
      if (ld_reg) begin
        d0 <= x;
        d1 <= d0;
        d2 <= d1;
      end
      if (ld_out) dp_y <= 16'((32'(d0) * 64 + 32'(d1) * 128 + 32'(d2) * 64) >> 8);
    end
  end

  // Reference model state (since last rst/clear).
  int m_hist[$];
  int got_y[$];
  int m_n, m_cnt, m_capt_idx, m_hold_idx;
  bit m_capt, m_hold, m_dp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int ref_y(input int i);
    int a, b, c;
    a = m_hist[i];
    b = (i >= 1) ? m_hist[i-1] : 0;
    c = (i >= 2) ? m_hist[i-2] : 0;
    return (64 * a + 128 * b + 64 * c) >> 8;
  endfunction

  task automatic step(input bit r, input bit c, input bit iv, input logic [15:0] xv, input bit ordy);
    bit ab, e_ir, e_ldr, e_ldo, e_warm, hs, nh;
    @(posedge clk);
    #1;
    rst = r; clear = c; in_valid = iv; x = xv; out_ready = ordy;
    @(negedge clk);
    ab     = r || c;
    e_ir   = !ab && !m_capt && (!m_hold || ordy);
    e_ldr  = iv && e_ir;
    e_ldo  = m_capt && !ab;
    e_warm = m_hold && (m_hold_idx < 2);
    check("in_ready", 32'(in_ready), 32'(e_ir));
    check("ld_reg", 32'(ld_reg), 32'(e_ldr));
    check("ld_out", 32'(ld_out), 32'(e_ldo));
    check("out_valid", 32'(out_valid), 32'(m_hold));
    check("out_warm", 32'(out_warm), 32'(e_warm));
    check("dp_rst", 32'(dp_rst), 32'(m_dp));
    check("sample_cnt", 32'(sample_cnt), 32'((m_cnt > 65535) ? 65535 : m_cnt));
    check("cnt3", 32'(sample_cnt3), 32'((m_cnt > 7) ? 7 : m_cnt));
    check("warm3", 32'(out_warm3), 32'(e_warm));
    check("hs3", 32'({in_ready3, ld_reg3, ld_out3, dp_rst3, out_valid3}),
          32'({e_ir, e_ldr, e_ldo, m_dp, m_hold}));
    if (m_hold) check("y", 32'(dp_y), 32'(ref_y(m_hold_idx)));
    if (m_hold && ordy && !ab) got_y.push_back(int'(dp_y));
    if (ab) begin
      m_capt = 0; m_hold = 0; m_n = 0; m_cnt = 0; m_dp = 1;
      m_hist.delete();
    end else begin
      m_dp = 0;
      hs   = m_hold && ordy;
      nh   = m_capt || (m_hold && !hs);
      if (m_capt) m_hold_idx = m_capt_idx;
      m_hold = nh;
      if (e_ldr) begin
        m_hist.push_back(int'(xv));
        m_capt_idx = m_n;
        m_n++;
        m_cnt++;
      end
      m_capt = e_ldr;
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x = 16'd0;
    m_capt = 0; m_hold = 0; m_dp = 1; m_n = 0; m_cnt = 0;
    m_capt_idx = 0; m_hold_idx = 0;
    repeat (2) @(posedge clk);
    step(1, 0, 0, 0, 0);

    // Constant stream of x=100 with a free downstream.
    got_y.delete();
    repeat (14) step(0, 0, 1, 16'd100, 1);
    check("stream_len", 32'(got_y.size() >= 4), 32'd1);
    if (got_y.size() >= 4) begin
      check("stream_y0", 32'(got_y[0]), 32'd25);
      check("stream_y1", 32'(got_y[1]), 32'd75);
      check("stream_y2", 32'(got_y[2]), 32'd100);
      check("stream_y3", 32'(got_y[3]), 32'd100);
    end

    // Downstream stall while upstream keeps offering.
    repeat (7) step(0, 0, 1, 16'd300, 0);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    step(0, 0, 1, 16'd300, 1);
    check("release_ld_reg", 32'(ld_reg), 32'd1);
    step(0, 0, 0, 0, 1);
    check("release_ld_out", 32'(ld_out), 32'd1);

    // Impulse response after a clear.
    step(0, 1, 0, 0, 1);
    got_y.delete();
    for (int i = 0; i < 30; i++) step(0, 0, m_n < 4, (m_n == 0) ? 16'd4 : 16'd0, 1);
    check("imp_cnt", 32'(sample_cnt), 32'd4);
    check("imp_len", 32'(got_y.size()), 32'd4);
    if (got_y.size() == 4) begin
      check("imp_y0", 32'(got_y[0]), 32'd1);
      check("imp_y1", 32'(got_y[1]), 32'd2);
      check("imp_y2", 32'(got_y[2]), 32'd1);
      check("imp_y3", 32'(got_y[3]), 32'd0);
    end

    // Clear arriving while a sample is being captured.
    for (int i = 0; i < 10 && !m_capt; i++) step(0, 0, 1, 16'd7, 1);
    check("capt_reached", 32'(m_capt), 32'd1);
    step(0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check("clr_dp_rst", 32'(dp_rst), 32'd1);
    check("clr_cnt", 32'(sample_cnt), 32'd0);
    check("clr_out_valid", 32'(out_valid), 32'd0);
    step(0, 0, 0, 0, 1);
    check("clr_out_valid2", 32'(out_valid), 32'd0);
    for (int i = 0; i < 8 && !out_valid; i++) step(0, 0, 1, 16'd9, 0);
    check("clr_next_valid", 32'(out_valid), 32'd1);
    check("clr_next_warm", 32'(out_warm), 32'd1);

    // Randomized traffic with occasional clear and reset.
    for (int i = 0; i < 10000; i++) begin
      step(($urandom % 700) == 0, ($urandom % 250) == 0, ($urandom % 4) != 0,
           16'($urandom), ($urandom % 3) != 0);
    end
    check("rand_cnt3_sat", 32'(m_cnt > 7 ? sample_cnt3 == 3'd7 : 1'b1), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_ctrl.md
FIR_CTRL -- requirements
Module: fir_ctrl

Interface
REQ-001 Parameter CNT_WIDTH, default 16: width of the accepted-sample counter.
REQ-002 Parameter WARMUP, default 2: number of initial outputs flagged as transient, equal to filter taps minus 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 clear  input  1  synchronous soft restart; same effect as rst on controller state.
REQ-006 in_valid  input  1  upstream sample present on datapath x.
REQ-007 in_ready  output  1  controller can accept a sample this cycle.
REQ-008 ld_reg  output  1  datapath input/delay-register load strobe.
REQ-009 ld_out  output  1  datapath output-register load strobe.
REQ-010 dp_rst  output  1  registered reset to datapath.
REQ-011 out_valid  output  1  datapath y holds a result not yet consumed.
REQ-012 out_ready  input  1  downstream accepts y this cycle.
REQ-013 out_warm  output  1  current result is a warm-up (transient) output.
REQ-014 sample_cnt  output  CNT_WIDTH  number of samples accepted since last rst/clear.

Function
REQ-015 FSM states SHALL be IDLE, CAPT, HOLD; encoding is free.
REQ-016 in_ready SHALL be 1 in IDLE, equal out_ready in HOLD, 0 in CAPT, and 0 whenever rst or clear is high.
REQ-017 ld_reg SHALL equal in_valid AND in_ready, combinationally; x is sampled by the datapath on that edge.
REQ-018 IDLE: on ld_reg go to CAPT; else stay.
REQ-019 CAPT: ld_out SHALL be 1 for exactly this one cycle; next state HOLD unconditionally.
REQ-020 HOLD: out_valid SHALL be 1 (registered, state-decoded); out_valid AND out_ready is the output handshake.
REQ-021 HOLD with output handshake and ld_reg in the same cycle SHALL go to CAPT (back-to-back, 2-cycle sample period).
REQ-022 HOLD with output handshake and no ld_reg SHALL go to IDLE; without handshake SHALL stay in HOLD, with ld_out 0 and y stable.
REQ-023 Latency: ld_reg at edge N; ld_out high in cycle N+1; out_valid high from cycle N+2.
REQ-024 Exactly one ld_out SHALL occur per accepted sample; ld_reg and ld_out SHALL never be high in the same cycle.
REQ-025 sample_cnt SHALL increment by 1 on each ld_reg and saturate at 2^CNT_WIDTH-1 (no wrap).
REQ-026 out_warm SHALL be 1 while out_valid=1 and the held result belongs to accepted sample index < WARMUP (index 0 = first after rst/clear), else 0.
REQ-027 out_warm SHALL be computed from a registered sample index latched at ld_reg, independent of sample_cnt saturation.
REQ-028 dp_rst SHALL be registered as rst OR clear: high the cycle after either is sampled high, low the cycle after both are low.
REQ-029 clear SHALL override every handshake: state to IDLE, pending result dropped, out_valid 0 next cycle, no ld_reg/ld_out while clear is high.

Reset
REQ-030 With rst high at an edge: state IDLE, out_valid 0, out_warm 0, sample_cnt 0, dp_rst 1 after that edge.
REQ-031 ld_reg, ld_out, in_ready SHALL be 0 in any cycle rst is high.
REQ-032 rst in any state (including CAPT, HOLD) SHALL abort the operation identically to reset from IDLE.

Verification
REQ-033 Reset release, in_valid=1, x=100, out_ready=1 constantly -> ld_reg, ld_out, out_valid pulses at 2-cycle period; y=25, 75, 100, 100, ...; out_warm 1 for first 2 outputs only.
REQ-034 out_ready=0 for 5 cycles in HOLD with in_valid=1 -> in_ready 0, no ld_reg/ld_out, y stable; out_ready=1 -> handshake and ld_reg same cycle, CAPT next.
REQ-035 Single x=4 impulse (16-bit, then zeros) -> y = 1, 2, 1, 0 (Q8 coefficients), sample_cnt=4.
REQ-036 clear asserted in CAPT -> out_valid never rises for that sample, sample_cnt 0, dp_rst 1 next cycle, next accepted sample shows out_warm 1.
REQ-037 CNT_WIDTH=3, feed 10 samples -> sample_cnt sticks at 7; out_warm unaffected.
REQ-038 Random in_valid/out_ready over 10k cycles -> no sample lost or duplicated, ld_reg/ld_out never simultaneous, y matches reference model.
